// File: rtl/fetch_align_queue_pkg.sv
// Shared definitions for the fetch/align queue: FSM encoding, widths, RVC detect.
package fetch_align_queue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned HALF_W  = 16;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_REQ  = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  // Little-endian instruction-memory word split into halfwords
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
  } fetch_word_t;

  function automatic logic is_rvc(input logic [HALF_W-1:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_queue_halfword_fifo.sv
// Circular halfword queue: 0/1/2-entry push and pop per cycle, synchronous flush.
module fetch_align_queue_halfword_fifo
  import fetch_align_queue_pkg::*;
#(
  parameter int unsigned QDEPTH = 6,
  parameter int unsigned DW     = HALF_W,
  parameter int unsigned CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic [1:0]    i_push_n,
  input  logic [DW-1:0] i_d0,
  input  logic [DW-1:0] i_d1,
  input  logic [1:0]    i_pop_n,
  output logic [DW-1:0] o_head0,
  output logic [DW-1:0] o_head1,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [DW-1:0] r_mem [QDEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_rd1;
  logic [PW-1:0] w_wr1;

  // Pointer advance modulo QDEPTH (depth need not be a power of two)
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(QDEPTH)) s = s - (PW+1)'(QDEPTH);
    return s[PW-1:0];
  endfunction

  assign w_rd1   = ptr_add(r_rd, 2'd1);
  assign w_wr1   = ptr_add(r_wr, 2'd1);
  assign o_head0 = r_mem[r_rd];
  assign o_head1 = r_mem[w_rd1];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push_n != 2'd0) r_mem[r_wr]  <= i_d0;
      if (i_push_n == 2'd2) r_mem[w_wr1] <= i_d1;
      r_wr  <= ptr_add(r_wr, i_push_n);
      r_rd  <= ptr_add(r_rd, i_pop_n);
      r_cnt <= r_cnt + CW'(i_push_n) - CW'(i_pop_n);
    end
  end

endmodule

// File: rtl/fetch_align_queue.sv
// Prefetch/align stage: fetches aligned words, queues halfwords, presents one raw instruction
// per handshake. Define FETCH_COMPRESSED_EN for 16-bit (RVC) instruction support.
module fetch_align_queue
  import fetch_align_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned QDEPTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_step,
  output logic               if_misalign
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fq_state_e         r_state;
  fq_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req;
  logic              r_skip_lo;
  logic              w_push_en;
  logic              w_pop;
  logic              w_room;
  logic [1:0]        w_push_n;
  logic [1:0]        w_pop_n;
  logic [HALF_W-1:0] w_d0;
  logic [HALF_W-1:0] w_d1;
  logic [HALF_W-1:0] w_head0;
  logic [HALF_W-1:0] w_head1;
  logic [CW-1:0]     w_count;
  fetch_word_t       w_word;
  logic              w_unused_addr0;

  assign w_word         = imem_rdata;
  assign w_unused_addr0 = redirect_addr[0];
  assign w_room         = (CW'(QDEPTH) - w_count) >= CW'(2);

  always_comb begin
    w_state_nxt = r_state;
    w_push_en   = 1'b0;
    unique case (r_state)
      FQ_IDLE: if (!redirect_valid && w_room) w_state_nxt = FQ_REQ;
      FQ_REQ: begin
        if (imem_rvalid) begin
          w_state_nxt = FQ_IDLE;
          w_push_en   = !redirect_valid;
        end else if (redirect_valid) begin
          w_state_nxt = FQ_DROP;
        end
      end
      FQ_DROP: if (imem_rvalid) w_state_nxt = FQ_IDLE;
      default: w_state_nxt = FQ_IDLE;
    endcase
  end

  // After a redirect into the upper half of a word, the first push keeps only that half
  assign w_push_n = !w_push_en ? 2'd0 : (r_skip_lo ? 2'd1 : 2'd2);
  assign w_d0     = r_skip_lo ? w_word.hi : w_word.lo;
  assign w_d1     = w_word.hi;

  fetch_align_queue_halfword_fifo #(
    .QDEPTH (QDEPTH),
    .DW     (HALF_W),
    .CW     (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .i_flush  (redirect_valid),
    .i_push_n (w_push_n),
    .i_d0     (w_d0),
    .i_d1     (w_d1),
    .i_pop_n  (w_pop_n),
    .o_head0  (w_head0),
    .o_head1  (w_head1),
    .o_count  (w_count)
  );

`ifdef FETCH_COMPRESSED_EN
  logic w_rvc;
  assign w_rvc       = is_rvc(w_head0);
  assign if_valid    = (w_count >= CW'(1) && w_rvc) || w_count >= CW'(2);
  assign if_step     = w_rvc;
  assign if_instr    = w_rvc ? {HALF_W'(0), w_head0} : {w_head1, w_head0};
  assign if_misalign = 1'b0;
`else
  logic r_misalign;
  // Halfword-aligned targets are unsupported without RVC; lock out until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_misalign <= 1'b0;
    else if (redirect_valid && redirect_addr[1]) r_misalign <= 1'b1;
  end
  assign if_valid    = !r_misalign && w_count >= CW'(2);
  assign if_step     = 1'b0;
  assign if_instr    = {w_head1, w_head0};
  assign if_misalign = r_misalign;
`endif

  assign w_pop     = if_valid && if_ready && !redirect_valid;
  assign w_pop_n   = !w_pop ? 2'd0 : (if_step ? 2'd1 : 2'd2);
  assign imem_req  = r_req;
  assign imem_addr = r_req_addr;
  assign if_pc     = r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FQ_IDLE;
      r_req      <= 1'b0;
      r_req_addr <= '0;
      r_fpc      <= '0;
      r_pc       <= '0;
      r_skip_lo  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt != FQ_IDLE);
      if (r_state == FQ_IDLE && w_state_nxt == FQ_REQ) r_req_addr <= r_fpc;
      if (redirect_valid) begin
        r_fpc     <= {redirect_addr[ADDR_W-1:2], 2'b00};
        r_pc      <= {redirect_addr[ADDR_W-1:1], 1'b0};
        r_skip_lo <= redirect_addr[1];
      end else begin
        if (w_push_en) begin
          r_fpc     <= r_fpc + ADDR_W'(4);
          r_skip_lo <= 1'b0;
        end
        if (w_pop) r_pc <= r_pc + (if_step ? ADDR_W'(2) : ADDR_W'(4));
      end
    end
  end

endmodule
